// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg: opcode constants, opcode check and one-hot FSM encodings
// Rev 1.0
`default_nettype none

package alu_cmd_sequencer_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;
  localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;

  typedef enum logic [4:0] {
    ST_RD_A  = 5'b00001,
    ST_RD_B  = 5'b00010,
    ST_RD_OP = 5'b00100,
    ST_EXEC  = 5'b01000,
    ST_WR    = 5'b10000
  } seq_state_t;

  function automatic logic is_valid_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default:                                                       is_valid_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sequencer_timeout.sv
// frame_timeout_counter: counts idle cycles while enabled; pulses expired on the LIMIT-th one
// Rev 1.0
`default_nettype none

module frame_timeout_counter #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CW-1:0] count;

  // LIMIT == 0 disables the timeout entirely
  assign expired = (LIMIT != 0) && en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear || expired) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: pops (A, B, opcode) frames from RX FIFO, runs the ALU, pushes the result
// Rev 1.0
`default_nettype none

module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int N              = 7,
  parameter int OP_W           = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_empty,
  input  logic [N:0]      r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [N:0]      w_data,
  output logic            wr_uart,
  output logic [N:0]      alu_a,
  output logic [N:0]      alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [N:0]      alu_result,
  output logic            busy,
  output logic            cmd_done,
  output logic            err_opcode,
  output logic            err_timeout
);

  seq_state_t state, state_next;
  logic       to_clear, to_en, to_expired;
  logic       op_ok;

  assign op_ok    = is_valid_op(r_data[OP_W-1:0]);
  assign busy     = (state != ST_RD_A);
  assign to_en    = ((state == ST_RD_B) || (state == ST_RD_OP)) && rx_empty;
  assign to_clear = rd_uart || (state == ST_RD_A);

  frame_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .en      (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RD_A;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      w_data <= '0;
    end else begin
      state <= state_next;
      if (state == ST_RD_A && rd_uart)           alu_a  <= r_data;
      if (state == ST_RD_B && rd_uart)           alu_b  <= r_data;
      if (state == ST_RD_OP && rd_uart && op_ok) alu_op <= r_data[OP_W-1:0];
      if (state == ST_EXEC)                      w_data <= alu_result;
    end
  end

  // Strobes are held off during reset so a pending push is discarded
  always_comb begin
    state_next  = state;
    rd_uart     = 1'b0;
    wr_uart     = 1'b0;
    cmd_done    = 1'b0;
    err_opcode  = 1'b0;
    err_timeout = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_RD_A: begin
          if (!rx_empty) begin
            rd_uart    = 1'b1;
            state_next = ST_RD_B;
          end
        end
        ST_RD_B: begin
          if (!rx_empty) begin
            rd_uart    = 1'b1;
            state_next = ST_RD_OP;
          end else if (to_expired) begin
            err_timeout = 1'b1;
            state_next  = ST_RD_A;
          end
        end
        ST_RD_OP: begin
          if (!rx_empty) begin
            rd_uart = 1'b1;
            if (op_ok) begin
              state_next = ST_EXEC;
            end else begin
              err_opcode = 1'b1;
              state_next = ST_RD_A;
            end
          end else if (to_expired) begin
            err_timeout = 1'b1;
            state_next  = ST_RD_A;
          end
        end
        ST_EXEC: begin
          state_next = ST_WR;
        end
        ST_WR: begin
          if (!tx_full) begin
            wr_uart    = 1'b1;
            cmd_done   = 1'b1;
            state_next = ST_RD_A;
          end
        end
        default: begin
          state_next = ST_RD_A;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed frames with hand-computed results against a small ALU model
// Rev 1.0
`default_nettype none

module tb_alu_cmd_sequencer;
  import alu_cmd_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [7:0] alu_a, alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_result;
  logic       busy, cmd_done, err_opcode, err_timeout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.N(7), .OP_W(6), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .alu_result(alu_result), .busy(busy), .cmd_done(cmd_done),
    .err_opcode(err_opcode), .err_timeout(err_timeout)
  );

  // Stand-in for the shared combinational ALU
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[2:0]);
      OP_SRL:  alu_result = alu_a >> alu_b[2:0];
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one rising edge
  task automatic push_byte(input logic [7:0] b);
    rx_empty = 1'b0;
    r_data   = b;
    #1 check_val("rd_uart_pop", rd_uart, 1);
    check_val("wr_during_rd", wr_uart, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    r_data   = 8'h00;
  endtask

  task automatic finish_frame(input logic [7:0] exp);
    check_val("exec_busy", busy, 1);
    check_val("exec_no_rd", rd_uart, 0);
    check_val("exec_no_wr", wr_uart, 0);
    @(negedge clk);
    check_val("wr_uart", wr_uart, 1);
    check_val("w_data", w_data, exp);
    check_val("cmd_done", cmd_done, 1);
    @(negedge clk);
    check_val("post_wr_strobe", wr_uart, 0);
    check_val("post_done", cmd_done, 0);
    check_val("post_busy", busy, 0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           input logic [7:0] exp);
    push_byte(a);
    push_byte(b);
    push_byte({2'b00, op});
    finish_frame(exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_alu_a", alu_a, 0);
    check_val("rst_alu_b", alu_b, 0);
    check_val("rst_alu_op", alu_op, 0);
    check_val("rst_w_data", w_data, 0);
    check_val("rst_strobes", {rd_uart, wr_uart, cmd_done, err_opcode, err_timeout}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_val("idle_no_pop", rd_uart, 0);

    run_frame(8'h05, 8'h03, OP_ADD, 8'h08);
    run_frame(8'hF0, 8'h20, OP_ADD, 8'h10);
    run_frame(8'h0F, 8'h01, OP_SUB, 8'h0E);
    run_frame(8'hAA, 8'h0F, OP_XOR, 8'hA5);
    run_frame(8'h80, 8'h03, OP_SRL, 8'h10);
    run_frame(8'h80, 8'h03, OP_SRA, 8'hF0);
    run_frame(8'hF0, 8'h0F, OP_NOR, 8'h00);

    // invalid opcode: frame dropped, alu_op keeps NOR
    push_byte(8'h01);
    push_byte(8'h02);
    rx_empty = 1'b0;
    r_data   = 8'h3F;
    #1 check_val("badop_pop", rd_uart, 1);
    check_val("err_opcode", err_opcode, 1);
    @(negedge clk);
    rx_empty = 1'b1;
    check_val("badop_busy", busy, 0);
    check_val("badop_no_wr", wr_uart, 0);
    check_val("badop_pulse_end", err_opcode, 0);
    check_val("badop_alu_op_kept", alu_op, OP_NOR);

    // timeout after A only
    push_byte(8'h55);
    for (int i = 1; i <= 10; i++) begin
      check_val("to_busy", busy, 1);
      check_val("err_timeout", err_timeout, (i == 10) ? 1 : 0);
      @(negedge clk);
    end
    check_val("to_back_idle", busy, 0);
    check_val("to_pulse_end", err_timeout, 0);
    check_val("to_alu_a_kept", alu_a, 8'h55);
    run_frame(8'h07, 8'h02, OP_SUB, 8'h05);

    // byte arriving on the expiry cycle wins
    push_byte(8'h11);
    repeat (9) begin
      check_val("pre_expiry_quiet", err_timeout, 0);
      @(negedge clk);
    end
    rx_empty = 1'b0;
    r_data   = 8'h22;
    #1 check_val("race_pop", rd_uart, 1);
    check_val("race_no_err", err_timeout, 0);
    @(negedge clk);
    rx_empty = 1'b1;
    push_byte({2'b00, OP_ADD});
    finish_frame(8'h33);

    // TX back-pressure
    tx_full = 1'b1;
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte({2'b00, OP_ADD});
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      check_val("full_no_wr", wr_uart, 0);
      check_val("full_w_data", w_data, 8'h46);
      @(negedge clk);
    end
    check_val("full_busy", busy, 1);
    tx_full = 1'b0;
    #1 check_val("release_wr", wr_uart, 1);
    check_val("release_done", cmd_done, 1);
    @(negedge clk);
    check_val("release_single", wr_uart, 0);
    check_val("release_idle", busy, 0);

    // reset while in RD_OP
    push_byte(8'h09);
    push_byte(8'h0A);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_op_busy", busy, 0);
    check_val("rst_op_alu_a", alu_a, 0);
    check_val("rst_op_alu_b", alu_b, 0);
    check_val("rst_op_alu_op", alu_op, 0);
    check_val("rst_op_w_data", w_data, 0);

    // reset while in WR: push discarded
    tx_full = 1'b1;
    push_byte(8'h01);
    push_byte(8'h01);
    push_byte({2'b00, OP_ADD});
    @(negedge clk);
    check_val("wr_pending_data", w_data, 8'h02);
    tx_full = 1'b0;
    reset   = 1'b1;
    #1 check_val("rst_wr_no_push", wr_uart, 0);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_wr_busy", busy, 0);
    check_val("rst_wr_w_data", w_data, 0);
    check_val("rst_wr_strobe", wr_uart, 0);
    @(negedge clk);
    check_val("rst_wr_still_quiet", wr_uart, 0);

    run_frame(8'h05, 8'h03, OP_ADD, 8'h08);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
